// File: rtl/cpu_clkctl.sv
// CPU clock and interrupt controller: programmable clkcpu divider with stall/wait freezing,
// and a raster-triggered /INT pulse whose length is counted in clkcpu periods.
module cpu_clkctl #(
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned WAIT_W = 3,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned HC_W   = 9,
    parameter int unsigned VC_W   = 9,
    parameter int unsigned TS_W   = 17
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              stall,
    input  logic              mreq,
    input  logic              iorq,
    input  logic              rd,
    input  logic              wr,
    input  logic [WAIT_W-1:0] wait_mem,
    input  logic [WAIT_W-1:0] wait_io,
    input  logic [HC_W-1:0]   hc,
    input  logic [VC_W-1:0]   vc,
    input  logic [HC_W-1:0]   int_h,
    input  logic [VC_W-1:0]   int_v,
    input  logic [LEN_W-1:0]  int_len,
    output logic              clkcpu,
    output logic              clkcpu_ck,
    output logic              clkwait,
    output logic              n_int_next,
    output logic              n_int,
    output logic [TS_W-1:0]   tstate
);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              clkcpu_q, clkcpu_d;
    logic              clkcpu_prev_q;
    logic              clkcpu_ck_q;
    logic              rdwr_q;
    logic              access_start;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LEN_W-1:0]  int_cnt_q, int_cnt_d;
    logic              n_int_next_q, n_int_next_d;
    logic              n_int_q, n_int_d;
    logic [TS_W-1:0]   tstate_q, tstate_d;

    assign clkwait      = (stall & clkcpu_q) | (wait_cnt_q != '0);
    assign access_start = (rd | wr) & ~rdwr_q;

    // ">=" lets a lowered div take effect immediately instead of wrapping the counter.
    always_comb begin
        div_cnt_d = div_cnt_q;
        clkcpu_d  = clkcpu_q;
        if (!clkwait) begin
            if (div_cnt_q >= div) begin
                div_cnt_d = '0;
                clkcpu_d  = ~clkcpu_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (access_start && mreq) begin
            wait_cnt_d = wait_mem;
        end else if (access_start && iorq) begin
            wait_cnt_d = wait_io;
        end else if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end
    end

    // Length is latched at start, so later int_len changes or raster hits cannot disturb a pulse.
    always_comb begin
        int_cnt_d    = int_cnt_q;
        n_int_next_d = n_int_next_q;
        if (int_cnt_q == '0) begin
            if ((vc == int_v) && (hc == int_h) && (int_len != '0)) begin
                int_cnt_d    = int_len;
                n_int_next_d = 1'b0;
            end
        end else if (clkcpu_ck_q) begin
            int_cnt_d = int_cnt_q - 1'b1;
            if (int_cnt_q == LEN_W'(1)) begin
                n_int_next_d = 1'b1;
            end
        end
    end

    always_comb begin
        n_int_d  = n_int_q;
        tstate_d = tstate_q;
        if (clkcpu_ck_q) begin
            n_int_d = n_int_next_q;
            if (n_int_q && !n_int_next_q) begin
                tstate_d = '0;
            end else begin
                tstate_d = tstate_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            clkcpu_q      <= 1'b0;
            clkcpu_prev_q <= 1'b0;
            clkcpu_ck_q   <= 1'b0;
            rdwr_q        <= 1'b0;
            wait_cnt_q    <= '0;
            int_cnt_q     <= '0;
            n_int_next_q  <= 1'b1;
            n_int_q       <= 1'b1;
            tstate_q      <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            clkcpu_q      <= clkcpu_d;
            clkcpu_prev_q <= clkcpu_q;
            clkcpu_ck_q   <= clkcpu_q & ~clkcpu_prev_q;
            rdwr_q        <= rd | wr;
            wait_cnt_q    <= wait_cnt_d;
            int_cnt_q     <= int_cnt_d;
            n_int_next_q  <= n_int_next_d;
            n_int_q       <= n_int_d;
            tstate_q      <= tstate_d;
        end
    end

    assign clkcpu     = clkcpu_q;
    assign clkcpu_ck  = clkcpu_ck_q;
    assign n_int_next = n_int_next_q;
    assign n_int      = n_int_q;
    assign tstate     = tstate_q;

endmodule

// File: tb/tb_cpu_clkctl.sv
// Directed bench for cpu_clkctl: divider timing, wait/stall freezing, INT pulse and async reset.
module tb_cpu_clkctl;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic [3:0]  div;
    logic        stall, mreq, iorq, rd, wr;
    logic [2:0]  wait_mem, wait_io;
    logic [8:0]  hc, vc, int_h, int_v;
    logic [7:0]  int_len;
    logic        clkcpu, clkcpu_ck, clkwait, n_int_next, n_int;
    logic [16:0] tstate;

    int checks   = 0;
    int failures = 0;
    int hi, ckn, cnt, wcnt;
    logic ok;

    cpu_clkctl dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .div        (div),
        .stall      (stall),
        .mreq       (mreq),
        .iorq       (iorq),
        .rd         (rd),
        .wr         (wr),
        .wait_mem   (wait_mem),
        .wait_io    (wait_io),
        .hc         (hc),
        .vc         (vc),
        .int_h      (int_h),
        .int_v      (int_v),
        .int_len    (int_len),
        .clkcpu     (clkcpu),
        .clkcpu_ck  (clkcpu_ck),
        .clkwait    (clkwait),
        .n_int_next (n_int_next),
        .n_int      (n_int),
        .tstate     (tstate)
    );

    always #5 clk28 = ~clk28;

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns just after the edge on which clkcpu goes to the requested level.
    task automatic wait_edge(input logic level, input string tag);
        logic prev;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            prev = clkcpu;
            tick();
            if (prev === ~level && clkcpu === level) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; div = 4'd3; stall = 1'b0; mreq = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0;
        wait_mem = 3'd0; wait_io = 3'd0; hc = 9'd0; vc = 9'd0; int_h = 9'd0; int_v = 9'd248;
        int_len = 8'd0;

        tick(); tick();
        chk("rst_clkcpu", {31'd0, clkcpu}, 32'd0);
        chk("rst_ck", {31'd0, clkcpu_ck}, 32'd0);
        chk("rst_n_int", {31'd0, n_int}, 32'd1);
        chk("rst_n_int_next", {31'd0, n_int_next}, 32'd1);
        chk("rst_tstate", {15'd0, tstate}, 32'd0);
        chk("rst_clkwait", {31'd0, clkwait}, 32'd0);

        // div=3: first rise on the 4th edge after release, then period 8 / high 4.
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("div3_pre_rise", {31'd0, clkcpu}, 32'd0);
        tick();
        chk("div3_rise", {31'd0, clkcpu}, 32'd1);
        chk("div3_ck_lag", {31'd0, clkcpu_ck}, 32'd0);
        tick();
        chk("div3_ck_on", {31'd0, clkcpu_ck}, 32'd1);
        tick();
        chk("div3_ck_off", {31'd0, clkcpu_ck}, 32'd0);
        tick(); tick();
        chk("div3_fall", {31'd0, clkcpu}, 32'd0);
        hi = 0; ckn = 0;
        repeat (8) begin
            tick();
            if (clkcpu === 1'b1) hi++;
            if (clkcpu_ck === 1'b1) ckn++;
        end
        chk("div3_high_cnt", hi, 4);
        chk("div3_ck_cnt", ckn, 1);

        // div_cnt reaches 2, then div drops to 0: toggle on the very next edge.
        tick(); tick();
        div = 4'd0;
        tick();
        chk("div0_imm_toggle", {31'd0, clkcpu}, 32'd1);
        tick();
        chk("div0_low", {31'd0, clkcpu}, 32'd0);
        chk("div0_ck", {31'd0, clkcpu_ck}, 32'd1);
        tick();
        chk("div0_high", {31'd0, clkcpu}, 32'd1);
        hi = 0;
        repeat (4) begin
            tick();
            if (clkcpu === 1'b1) hi++;
        end
        chk("div0_period2", hi, 2);

        // Memory wait of 2 with div=1 stretches the high phase by 2 cycles.
        div = 4'd1; wait_mem = 3'd2; wait_io = 3'd5;
        wait_edge(1'b1, "rise_timeout_mem");
        mreq = 1'b1; rd = 1'b1;
        tick();
        chk("mem_wait_w1", {31'd0, clkwait}, 32'd1);
        tick();
        chk("mem_wait_w2", {31'd0, clkwait}, 32'd1);
        chk("mem_wait_hold", {31'd0, clkcpu}, 32'd1);
        tick();
        chk("mem_wait_end", {31'd0, clkwait}, 32'd0);
        chk("mem_wait_still_hi", {31'd0, clkcpu}, 32'd1);
        tick();
        chk("mem_wait_toggle", {31'd0, clkcpu}, 32'd0);
        mreq = 1'b0; rd = 1'b0;

        // I/O write with wait_io=5.
        wait_edge(1'b1, "rise_timeout_io");
        iorq = 1'b1; wr = 1'b1;
        wcnt = 0;
        repeat (6) begin
            tick();
            if (clkwait === 1'b1) wcnt++;
        end
        chk("io_wait_cnt", wcnt, 5);
        chk("io_wait_hold", {31'd0, clkcpu}, 32'd1);
        tick();
        chk("io_wait_toggle", {31'd0, clkcpu}, 32'd0);
        iorq = 1'b0; wr = 1'b0;

        // wait_mem=0 inserts nothing.
        wait_mem = 3'd0;
        wait_edge(1'b1, "rise_timeout_w0");
        mreq = 1'b1; rd = 1'b1;
        tick();
        chk("w0_no_wait", {31'd0, clkwait}, 32'd0);
        tick();
        chk("w0_toggle", {31'd0, clkcpu}, 32'd0);
        mreq = 1'b0; rd = 1'b0;

        // Stall for 10 cycles starting in the low phase.
        div = 4'd3;
        wait_edge(1'b0, "fall_timeout_stall");
        stall = 1'b1;
        hi = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (clkcpu === 1'b1) hi++;
            if (i == 3) chk("stall_low_runs", {31'd0, clkcpu}, 32'd0);
            if (i == 5) chk("stall_clkwait", {31'd0, clkwait}, 32'd1);
            if (i == 10) begin
                stall = 1'b0;
                #1;
                chk("stall_release", {31'd0, clkwait}, 32'd0);
            end
        end
        chk("stall_high_cnt", hi, 10);
        chk("stall_fall", {31'd0, clkcpu}, 32'd0);

        // INT pulse of 32 T-states at div=3.
        wait_edge(1'b1, "rise_timeout_int");
        tick(); tick();
        vc = 9'd248; int_len = 8'd32;
        tick();
        vc = 9'd0;
        chk("int_next_fall", {31'd0, n_int_next}, 32'd0);
        chk("int_not_yet", {31'd0, n_int}, 32'd1);
        cnt = 0;
        while (n_int !== 1'b0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("int_fall_delay", cnt, 7);
        chk("int_tstate0", {15'd0, tstate}, 32'd0);
        cnt = 0;
        while (n_int === 1'b0 && cnt < 400) begin
            if (cnt == 100) begin
                vc = 9'd248; int_len = 8'd5;
            end
            if (cnt == 101) vc = 9'd0;
            tick();
            cnt++;
            if (cnt == 8) chk("int_tstate1", {15'd0, tstate}, 32'd1);
        end
        chk("int_low_len", cnt, 256);
        chk("int_next_high", {31'd0, n_int_next}, 32'd1);

        // int_len=0 disables INT despite a raster match.
        int_len = 8'd0; vc = 9'd248;
        tick();
        vc = 9'd0;
        ok = 1'b1;
        repeat (300) begin
            tick();
            if (n_int !== 1'b1 || n_int_next !== 1'b1) ok = 1'b0;
        end
        chk("int_len0_quiet", {31'd0, ok}, 32'd1);

        // Async reset in the middle of an INT pulse and a memory wait.
        int_len = 8'd32; vc = 9'd248;
        tick();
        vc = 9'd0;
        cnt = 0;
        while (n_int !== 1'b0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("int2_low", {31'd0, n_int}, 32'd0);
        wait_mem = 3'd7; mreq = 1'b1; rd = 1'b1;
        tick();
        chk("rst_pre_wait", {31'd0, clkwait}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_n_int", {31'd0, n_int}, 32'd1);
        chk("arst_clkcpu", {31'd0, clkcpu}, 32'd0);
        chk("arst_clkwait", {31'd0, clkwait}, 32'd0);
        chk("arst_tstate", {15'd0, tstate}, 32'd0);
        mreq = 1'b0; rd = 1'b0; div = 4'd1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rel_div1_e1", {31'd0, clkcpu}, 32'd0);
        tick();
        chk("rel_div1_e2", {31'd0, clkcpu}, 32'd1);
        chk("rel_n_int", {31'd0, n_int}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
